branch_resolve_unit: RTL
========================

// Module: branch_resolve_unit
// PURPOSE
//  Other end of the predictor loop. Buffers each issued prediction in flight and compares it
//  in order with the resolved branch outcome. Returns the actual outcome to the saturating-
//  counter predictor as its 'taken' training input, and raises a mispredict/flush pulse.
//  Sits between the fetch stage (prediction producer) and execute (outcome producer).
// PARAMETERS
//  DEPTH    4   in-flight prediction queue entries (power of 2, >=2)
//  CNT_W    16  width of performance counters (only with BRU_PERF_CNT_EN)
// PORTS
//  clk            in   1        single clock, all logic on posedge
//  reset          in   1        synchronous, active-high
//  pred_valid     in   1        fetch issues a prediction this cycle
//  pred_state     in   2        state_t counter state sampled at fetch (MSB = predicted taken)
//  pred_ready     out  1        queue can accept (= !full)
//  res_valid      in   1        execute resolves oldest in-flight branch
//  res_taken      in   1        actual outcome
//  upd_valid      out  1        training update valid (drives predictor clock-enable)
//  upd_taken      out  1        actual outcome to predictor 'taken'
//  mispredict     out  1        1-cycle pulse: predicted dir != actual
//  err_underflow  out  1        sticky: res_valid seen with empty queue
//  occupancy      out  $clog2(DEPTH)+1  entries in flight
// BEHAVIOUR
//  - Reset (reset=1 at posedge): queue empty, occupancy=0, pred_ready=1, upd_valid=0,
//    upd_taken=0, mispredict=0, err_underflow=0, counters=0. Reset mid-operation discards all
//    in-flight entries the same edge.
//  - Push: pred_valid && pred_ready -> pred_state written at tail. Push while full is dropped;
//    queue contents unchanged. pred_ready depends only on full (no pop look-through).
//  - Resolve: res_valid && !empty -> pop head; compare head[1] with res_taken.
//    Next cycle (1-cycle latency, registered): upd_valid=1, upd_taken=res_taken,
//    mispredict=(head[1]!=res_taken). All three are 0 in any cycle not following a resolve.
//  - Mispredict flush: on the resolving edge with mismatch, the queue is fully cleared
//    (all younger entries are wrong-path). A push in that same cycle is discarded.
//  - Simultaneous push+pop without mismatch: both occur; occupancy unchanged; legal when full
//    only if pred_ready was 1 (i.e. never pushes into full).
//  - Underflow: res_valid with empty queue -> no pop, no update, err_underflow set until reset.
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; full/empty come from occupancy.
//  - Control FSM states: IDLE (empty), ACTIVE (1..DEPTH-1), FULL (DEPTH). Transitions follow
//    occupancy; any mispredict -> IDLE regardless of state; reset -> IDLE.
// CONFIGURATION
//  BRU_PERF_CNT_EN defined: adds outputs resolved_cnt[CNT_W-1:0] and mispred_cnt[CNT_W-1:0];
//    increment on each valid resolve / each mispredict; saturate at all-ones; cleared by reset.
//  Not defined: those ports and registers do not exist; all other behaviour identical.
// STRUCTURE
//  - bp_pkg: reuse state_t (SNT=00, WNT=01, WT=10, ST=11); add function pred_dir(state_t)
//    returning MSB, and br_ev_t struct {valid, taken, mispredict} for the update bundle.
//  - One sub-module: bru_fifo (DEPTH x 2-bit sync FIFO with push, pop, clear, occupancy).
//    Top holds the FSM, compare, output registers and optional counters.
// TESTING
//  1. Reset held 3 cycles with pred_valid=1 -> occupancy=0, pred_ready=1, all flags 0.
//  2. Push ST,SNT; resolve taken, then not-taken -> upd_taken 1 then 0, mispredict 0 both, occupancy 0.
//  3. Push WT,WT,WNT; resolve not-taken -> next cycle mispredict=1, upd_taken=0, occupancy=0
//     (younger two flushed); a push on the flush cycle is also discarded.
//  4. DEPTH=4: push 5 times -> pred_ready=0 after 4th, 5th dropped; pop+push when full
//     blocked until pop frees a slot; occupancy stays <=4.
//  5. res_valid=1 with empty queue -> upd_valid=0, err_underflow=1, stays 1 until reset.
//  6. With BRU_PERF_CNT_EN, CNT_W=4: 20 mispredicting resolves -> mispred_cnt=15 (saturated),
//     resolved_cnt=15.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared branch-predictor types: 2-bit counter state, predicted-direction helper
// and the training-update bundle returned to the predictor.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } state_t;

    typedef struct packed {
        logic valid;
        logic taken;
        logic mispredict;
    } br_ev_t;

    function automatic logic pred_dir(input state_t s);
        return s[1];
    endfunction

endpackage

// File: rtl/bru_fifo.sv
// DEPTH x 2-bit synchronous FIFO holding in-flight predictions; clear empties it
// on the same edge and overrides push/pop.
module bru_fifo
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  state_t                   wr_data,
    output state_t                   rd_data,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    state_t             mem_q [DEPTH];
    state_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + OCC_W'(1);
                2'b01:   count_d = count_q - OCC_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= SNT;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data   = mem_q[rd_ptr_q];
    assign occupancy = count_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Buffers issued predictions, resolves them in order against execute outcomes, and
// returns training updates plus a mispredict flush. Optional perf counters: BRU_PERF_CNT_EN.
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH = 4
`ifdef BRU_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pred_valid,
    input  logic [1:0]               pred_state,
    output logic                     pred_ready,
    input  logic                     res_valid,
    input  logic                     res_taken,
    output logic                     upd_valid,
    output logic                     upd_taken,
    output logic                     mispredict,
    output logic                     err_underflow,
    output logic [$clog2(DEPTH):0]   occupancy
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]         resolved_cnt,
    output logic [CNT_W-1:0]         mispred_cnt
`endif
);

    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    localparam logic [1:0] FSM_IDLE   = 2'd0;
    localparam logic [1:0] FSM_ACTIVE = 2'd1;
    localparam logic [1:0] FSM_FULL   = 2'd2;

    logic [1:0]  state_q, state_d;
    br_ev_t      ev_q, ev_d;
    logic        err_q, err_d;

    state_t      head;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic        flush;

    // FSM state tracks occupancy exactly, so empty/full can be read from it
    assign empty = (state_q == FSM_IDLE);
    assign full  = (state_q == FSM_FULL);

    assign pop   = res_valid && !empty;
    assign flush = pop && (pred_dir(head) != res_taken);
    assign push  = pred_valid && !full && !flush;

    bru_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .clear     (flush),
        .wr_data   (state_t'(pred_state)),
        .rd_data   (head),
        .occupancy (occupancy)
    );

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = FSM_IDLE;
        end else begin
            case (state_q)
                FSM_IDLE: begin
                    if (push) state_d = FSM_ACTIVE;
                end
                FSM_ACTIVE: begin
                    if (push && !pop && occupancy == OCC_W'(DEPTH - 1)) begin
                        state_d = FSM_FULL;
                    end else if (pop && !push && occupancy == OCC_W'(1)) begin
                        state_d = FSM_IDLE;
                    end
                end
                FSM_FULL: begin
                    if (pop) state_d = FSM_ACTIVE;
                end
                default: state_d = FSM_IDLE;
            endcase
        end
    end

    always_comb begin
        ev_d.valid      = pop;
        ev_d.taken      = pop && res_taken;
        ev_d.mispredict = flush;
        err_d           = err_q || (res_valid && empty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FSM_IDLE;
            ev_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ev_q    <= ev_d;
            err_q   <= err_d;
        end
    end

    assign pred_ready    = !full;
    assign upd_valid     = ev_q.valid;
    assign upd_taken     = ev_q.taken;
    assign mispredict    = ev_q.mispredict;
    assign err_underflow = err_q;

`ifdef BRU_PERF_CNT_EN
    logic [CNT_W-1:0] resolved_cnt_q, resolved_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    always_comb begin
        resolved_cnt_d = resolved_cnt_q;
        mispred_cnt_d  = mispred_cnt_q;
        if (pop && resolved_cnt_q != '1) resolved_cnt_d = resolved_cnt_q + CNT_W'(1);
        if (flush && mispred_cnt_q != '1) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resolved_cnt_q <= '0;
            mispred_cnt_q  <= '0;
        end else begin
            resolved_cnt_q <= resolved_cnt_d;
            mispred_cnt_q  <= mispred_cnt_d;
        end
    end

    assign resolved_cnt = resolved_cnt_q;
    assign mispred_cnt  = mispred_cnt_q;
`endif

endmodule
